// File: rtl/pipelined_datapath_pkg.sv
// pipelined_datapath_pkg: shared types for the two-stage datapath.
// Provides the ALU op codes, the X/O stage bundles and a register-index width helper.
package pipelined_datapath_pkg;

   // Register-index width; a single register still needs one address bit.
   function automatic int reg_idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Default geometry; the stage bundles are sized from these, so the
   // top-level XLEN/NREGS/IMM_W parameters must stay equal to them.
   localparam int DP_XLEN  = 32;
   localparam int DP_NREGS = 32;
   localparam int DP_IMM_W = 16;
   localparam int DP_RW    = reg_idx_w(DP_NREGS);

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_SLL = 4'b1000,
      ALU_SRL = 4'b1001,
      ALU_SRA = 4'b1010,
      ALU_NOR = 4'b1100
   } alu_op_e;

   // Execute-input stage; op is kept raw so unlisted codes pass through
   // to the ALU default (result 0) without an enum cast.
   typedef struct packed {
      logic                valid;
      logic [DP_RW-1:0]    rs;
      logic [DP_RW-1:0]    rt;
      logic [DP_RW-1:0]    rd;
      logic [DP_XLEN-1:0]  a;
      logic [DP_XLEN-1:0]  b;
      logic [DP_XLEN-1:0]  imm;
      logic                alu_src;
      logic [3:0]          op;
      logic                reg_write;
   } x_stage_t;

   typedef struct packed {
      logic                valid;
      logic [DP_XLEN-1:0]  result;
      logic                zero;
      logic                ovfl;
      logic [DP_RW-1:0]    rd;
      logic                reg_write;
   } o_stage_t;

endpackage

// File: rtl/pipelined_datapath_regfile.sv
// regfile_2r1w: two async read ports, one sync write port, async active-high clear.
// Ports: clk, reset, ra/rb -> da/db (read), we/wa/wd (write); r0 reads 0, writes bypass to reads.
module regfile_2r1w
   import pipelined_datapath_pkg::*;
#(
   parameter int XLEN  = DP_XLEN,
   parameter int NREGS = DP_NREGS,
   parameter int RW    = reg_idx_w(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RW-1:0]   ra,
   input  logic [RW-1:0]   rb,
   output logic [XLEN-1:0] da,
   output logic [XLEN-1:0] db,
   input  logic            we,
   input  logic [RW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // Same-cycle write is visible to readers so a value committed while
   // a dependent instruction is being accepted is not lost.
   assign da = (ra == '0)            ? '0 :
               (we && (wa == ra))    ? wd : regs[ra];
   assign db = (rb == '0)            ? '0 :
               (we && (wa == rb))    ? wd : regs[rb];

endmodule

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: two-stage (X, O) register-read / ALU datapath with
// its own register file and write-back. Ports: clk, reset; in_valid/in_ready
// with rs/rt/rd_number, imm, alu_src, alu_control, reg_write; out_valid/out_ready
// with alu_result, zero, ovfl.
module pipelined_datapath
   import pipelined_datapath_pkg::*;
#(
   parameter int XLEN  = DP_XLEN,
   parameter int NREGS = DP_NREGS,
   parameter int IMM_W = DP_IMM_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [$clog2(NREGS)-1:0] rs_number,
   input  logic [$clog2(NREGS)-1:0] rt_number,
   input  logic [$clog2(NREGS)-1:0] rd_number,
   input  logic [IMM_W-1:0]         imm,
   input  logic                     alu_src,
   input  logic [3:0]               alu_control,
   input  logic                     reg_write,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          alu_result,
   output logic                     zero,
   output logic                     ovfl
);

   localparam int SW = $clog2(XLEN);

   x_stage_t x_q;
   o_stage_t o_q;

   logic            accept;
   logic            advance;
   logic            commit;
   logic            fwd_a;
   logic            fwd_b;
   logic            ov;
   logic [XLEN-1:0] rf_a;
   logic [XLEN-1:0] rf_b;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] res;

   assign commit   = o_q.valid & out_ready;
   assign advance  = x_q.valid & (~o_q.valid | commit);
   assign in_ready = ~x_q.valid | advance;
   assign accept   = in_valid & in_ready;

   assign out_valid  = o_q.valid;
   assign alu_result = o_q.result;
   assign zero       = o_q.zero;
   assign ovfl       = o_q.ovfl;

   regfile_2r1w #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_rf (
      .clk   (clk),
      .reset (reset),
      .ra    (rs_number),
      .rb    (rt_number),
      .da    (rf_a),
      .db    (rf_b),
      .we    (commit & o_q.reg_write),
      .wa    (o_q.rd),
      .wd    (o_q.result)
   );

   assign imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

   // O holds the one result X may have missed at operand capture.
   assign fwd_a = o_q.valid & o_q.reg_write & (o_q.rd != '0)
                & (o_q.rd == x_q.rs);
   assign fwd_b = o_q.valid & o_q.reg_write & (o_q.rd != '0)
                & (o_q.rd == x_q.rt) & ~x_q.alu_src;

   assign op_a = fwd_a ? o_q.result : x_q.a;
   assign op_b = x_q.alu_src ? x_q.imm
               : (fwd_b ? o_q.result : x_q.b);

   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   always_comb begin
      res = '0;
      ov  = 1'b0;
      case (x_q.op)
         ALU_AND: res = op_a & op_b;
         ALU_OR:  res = op_a | op_b;
         ALU_XOR: res = op_a ^ op_b;
         ALU_NOR: res = ~(op_a | op_b);
         ALU_ADD: begin
            res = sum;
            ov  = (op_a[XLEN-1] == op_b[XLEN-1])
                & (sum[XLEN-1] != op_a[XLEN-1]);
         end
         ALU_SUB: begin
            res = diff;
            ov  = (op_a[XLEN-1] != op_b[XLEN-1])
                & (diff[XLEN-1] != op_a[XLEN-1]);
         end
         ALU_SLT: res = {{(XLEN-1){1'b0}},
                         $signed(op_a) < $signed(op_b)};
         ALU_SLL: res = op_a << op_b[SW-1:0];
         ALU_SRL: res = op_a >> op_b[SW-1:0];
         ALU_SRA: res = XLEN'($signed(op_a) >>> op_b[SW-1:0]);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= '0;
         o_q <= '0;
      end else begin
         if (advance) begin
            o_q.valid     <= 1'b1;
            o_q.result    <= res;
            o_q.zero      <= (res == '0);
            o_q.ovfl      <= ov;
            o_q.rd        <= x_q.rd;
            o_q.reg_write <= x_q.reg_write;
         end else if (commit) begin
            o_q.valid <= 1'b0;
         end

         if (accept) begin
            x_q.valid     <= 1'b1;
            x_q.rs        <= rs_number;
            x_q.rt        <= rt_number;
            x_q.rd        <= rd_number;
            x_q.a         <= rf_a;
            x_q.b         <= rf_b;
            x_q.imm       <= imm_ext;
            x_q.alu_src   <= alu_src;
            x_q.op        <= alu_control;
            x_q.reg_write <= reg_write;
         end else if (advance) begin
            x_q.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_datapath.sv
// tb_pipelined_datapath: directed scenario tasks plus a randomized run
// checked against an in-order architectural model of the datapath.
module tb_pipelined_datapath;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  rs_number = '0;
   logic [4:0]  rt_number = '0;
   logic [4:0]  rd_number = '0;
   logic [15:0] imm = '0;
   logic        alu_src = 1'b0;
   logic [3:0]  alu_control = '0;
   logic        reg_write = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] alu_result;
   logic        zero;
   logic        ovfl;

   always #5 clk = ~clk;

   pipelined_datapath dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .rs_number   (rs_number),
      .rt_number   (rt_number),
      .rd_number   (rd_number),
      .imm         (imm),
      .alu_src     (alu_src),
      .alu_control (alu_control),
      .reg_write   (reg_write),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_result  (alu_result),
      .zero        (zero),
      .ovfl        (ovfl)
   );

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ov;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mrf [32];
   int          total = 0;
   int          bad = 0;

   logic        acc, com, o_rdy, o_vld, o_z, o_ov;
   logic [31:0] o_res;

   logic [3:0]  ops [11] = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB,
                             OP_SLT, OP_SLL, OP_SRL, OP_SRA, OP_NOR,
                             4'b1111};

   function automatic exp_t model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t   r;
      longint sa, sb, s;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      r.res = '0;
      r.ov  = 1'b0;
      case (op)
         OP_AND: r.res = a & b;
         OP_OR:  r.res = a | b;
         OP_XOR: r.res = a ^ b;
         OP_NOR: r.res = ~(a | b);
         OP_ADD: begin
            s = sa + sb;
            r.res = 32'(s);
            r.ov = (s > SMAX) || (s < SMIN);
         end
         OP_SUB: begin
            s = sa - sb;
            r.res = 32'(s);
            r.ov = (s > SMAX) || (s < SMIN);
         end
         OP_SLT: r.res = (sa < sb) ? 32'd1 : 32'd0;
         OP_SLL: r.res = a << b[4:0];
         OP_SRL: r.res = a >> b[4:0];
         OP_SRA: r.res = 32'(sa >>> b[4:0]);
         default: ;
      endcase
      r.z = (r.res == 32'd0);
      return r;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      exp_q.delete();
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] im, input logic src,
                        input logic rw);
      in_valid    = 1'b1;
      alu_control = op;
      rs_number   = rs;
      rt_number   = rt;
      rd_number   = rd;
      imm         = im;
      alu_src     = src;
      reg_write   = rw;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // One cycle: sample just after the negedge, update the model on
   // accept, then return at the next negedge.
   task automatic step();
      logic [31:0] a, b;
      exp_t e;
      #1;
      o_rdy = in_ready;
      o_vld = out_valid;
      acc   = in_valid & in_ready;
      com   = out_valid & out_ready;
      o_res = alu_result;
      o_z   = zero;
      o_ov  = ovfl;
      if (acc) begin
         a = (rs_number == 0) ? 32'd0 : mrf[rs_number];
         b = alu_src ? {{16{imm[15]}}, imm}
           : ((rt_number == 0) ? 32'd0 : mrf[rt_number]);
         e = model(alu_control, a, b);
         exp_q.push_back(e);
         if (reg_write && rd_number != 0) mrf[rd_number] = e.res;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      exp_t e;
      idle();
      out_ready = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_model();
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== 32'd0
          || zero !== 1'b0 || ovfl !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: rdy=%b vld=%b res=%h z=%b ov=%b want 1 0 0 0 0",
                  in_ready, out_valid, alu_result, zero, ovfl);
      end
      @(negedge clk);
      drive(OP_ADD, 0, 0, 1, 16'h0055, 1'b1, 1'b1); step();
      drive(OP_ADD, 1, 0, 3, 16'h0000, 1'b0, 1'b0); step();
      idle();
      n = 0;
      for (int c = 0; c < 10 && n < 2; c++) begin
         step();
         if (com) begin
            e = exp_q.pop_front();
            total++;
            if (o_res !== 32'h55) begin
               bad++;
               $display("FAIL reset_pre_%0d: got %h want 00000055", n, o_res);
            end
            n++;
         end
      end
      total++;
      if (n != 2) begin
         bad++;
         $display("FAIL reset_pre_count: got %0d want 2", n);
      end
      out_ready = 1'b0;
      drive(OP_ADD, 0, 0, 1, 16'h0AAA, 1'b1, 1'b1); step();
      drive(OP_ADD, 0, 0, 2, 16'h0BBB, 1'b1, 1'b1); step();
      idle(); step();
      #2 reset = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || alu_result !== 32'd0) begin
         bad++;
         $display("FAIL reset_async: vld=%b res=%h want 0 0", out_valid, alu_result);
      end
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      clear_model();
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      drive(OP_ADD, 1, 2, 3, 16'h0000, 1'b0, 1'b0); step();
      idle();
      n = 0;
      for (int c = 0; c < 10 && n < 1; c++) begin
         step();
         if (com) begin
            e = exp_q.pop_front();
            n++;
            total++;
            if (o_res !== 32'd0 || o_z !== 1'b1) begin
               bad++;
               $display("FAIL reset_read: got %h z=%b want 0 z=1", o_res, o_z);
            end
         end
      end
      total++;
      if (n != 1) begin
         bad++;
         $display("FAIL reset_read_count: got %0d want 1", n);
      end
   endtask

   task automatic test_imm();
      logic [31:0] want [2] = '{32'h5, 32'hFFFFFFFF};
      int n;
      exp_t e;
      out_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) drive(OP_ADD, 0, 0, 1, 16'h0005, 1'b1, 1'b1);
         else if (k == 1) drive(OP_ADD, 0, 0, 2, 16'hFFFF, 1'b1, 1'b1);
         else idle();
         step();
         if (com && n < 2) begin
            e = exp_q.pop_front();
            total++;
            if (o_res !== want[n] || k != n + 2) begin
               bad++;
               $display("FAIL imm_%0d: got %h at cycle %0d want %h at cycle %0d",
                        n, o_res, k, want[n], n + 2);
            end
            n++;
         end
      end
      total++;
      if (n != 2) begin
         bad++;
         $display("FAIL imm_count: got %0d want 2", n);
      end
   endtask

   task automatic test_forward();
      logic [31:0] want [3] = '{32'd7, 32'd14, 32'd7};
      int n;
      exp_t e;
      out_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 9; k++) begin
         if (k == 0) drive(OP_ADD, 0, 0, 1, 16'd7, 1'b1, 1'b1);
         else if (k == 1) drive(OP_ADD, 1, 1, 2, 16'd0, 1'b0, 1'b1);
         else if (k == 2) drive(OP_SUB, 2, 1, 3, 16'd0, 1'b0, 1'b1);
         else idle();
         step();
         if (com && n < 3) begin
            e = exp_q.pop_front();
            total++;
            if (o_res !== want[n] || k != n + 2) begin
               bad++;
               $display("FAIL fwd_%0d: got %h at cycle %0d want %h at cycle %0d",
                        n, o_res, k, want[n], n + 2);
            end
            n++;
         end
      end
      total++;
      if (n != 3) begin
         bad++;
         $display("FAIL fwd_count: got %0d want 3", n);
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] want [3] = '{32'h100, 32'h200, 32'h300};
      int n;
      exp_t e;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         out_ready = (k >= 6);
         if (k == 0) drive(OP_ADD, 0, 0, 4, 16'h0100, 1'b1, 1'b1);
         else if (k == 1) drive(OP_ADD, 4, 0, 5, 16'h0100, 1'b1, 1'b1);
         else if (k <= 6) drive(OP_ADD, 4, 5, 6, 16'h0000, 1'b0, 1'b1);
         else idle();
         step();
         if (k >= 2 && k <= 5) begin
            total++;
            if (o_rdy !== 1'b0 || o_vld !== 1'b1 || o_res !== 32'h100
                || o_z !== 1'b0 || acc) begin
               bad++;
               $display("FAIL stall_%0d: rdy=%b vld=%b res=%h acc=%b want 0 1 00000100 0",
                        k, o_rdy, o_vld, o_res, acc);
            end
         end
         if (com && n < 3) begin
            e = exp_q.pop_front();
            total++;
            if (o_res !== want[n] || k != n + 6) begin
               bad++;
               $display("FAIL bp_%0d: got %h at cycle %0d want %h at cycle %0d",
                        n, o_res, k, want[n], n + 6);
            end
            n++;
         end
      end
      total++;
      if (n != 3) begin
         bad++;
         $display("FAIL bp_count: got %0d want 3", n);
      end
   endtask

   task automatic test_ovfl_zero();
      logic [31:0] want [7] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                                32'd5, 32'd0, 32'd1, 32'h7FFFFFFF};
      logic        wz   [7] = '{0, 0, 0, 0, 1, 0, 0};
      logic        wov  [7] = '{0, 0, 1, 0, 0, 0, 1};
      int n;
      exp_t e;
      out_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         case (k)
            0: drive(OP_ADD, 0, 0, 7, 16'hFFFF, 1'b1, 1'b1);
            1: drive(OP_SRL, 7, 0, 8, 16'd1, 1'b1, 1'b1);
            2: drive(OP_ADD, 8, 0, 9, 16'd1, 1'b1, 1'b1);
            3: drive(OP_ADD, 0, 0, 10, 16'd5, 1'b1, 1'b1);
            4: drive(OP_SUB, 10, 0, 11, 16'd5, 1'b1, 1'b1);
            5: drive(OP_SLT, 7, 0, 12, 16'd1, 1'b1, 1'b1);
            6: drive(OP_SUB, 9, 0, 13, 16'd1, 1'b1, 1'b1);
            default: idle();
         endcase
         step();
         if (com && n < 7) begin
            e = exp_q.pop_front();
            total++;
            if (o_res !== want[n] || o_z !== wz[n] || o_ov !== wov[n]) begin
               bad++;
               $display("FAIL arith_%0d: got %h z=%b ov=%b want %h z=%b ov=%b",
                        n, o_res, o_z, o_ov, want[n], wz[n], wov[n]);
            end
            n++;
         end
      end
      total++;
      if (n != 7) begin
         bad++;
         $display("FAIL arith_count: got %0d want 7", n);
      end
   endtask

   task automatic test_reg0();
      logic [31:0] want [3] = '{32'h1234, 32'd0, 32'd0};
      int n;
      exp_t e;
      out_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) drive(OP_ADD, 0, 0, 0, 16'h1234, 1'b1, 1'b1);
         else if (k == 1) drive(OP_ADD, 0, 0, 14, 16'd0, 1'b0, 1'b1);
         else if (k == 2) drive(OP_ADD, 0, 0, 15, 16'd0, 1'b0, 1'b1);
         else idle();
         step();
         if (com && n < 3) begin
            e = exp_q.pop_front();
            total++;
            if (o_res !== want[n] || o_z !== (want[n] == 32'd0)) begin
               bad++;
               $display("FAIL r0_%0d: got %h z=%b want %h", n, o_res, o_z, want[n]);
            end
            n++;
         end
      end
      total++;
      if (n != 3) begin
         bad++;
         $display("FAIL r0_count: got %0d want 3", n);
      end
   endtask

   task automatic test_random();
      int   issued;
      logic stall_prev;
      logic [31:0] res_prev;
      exp_t e;
      issued     = 0;
      stall_prev = 1'b0;
      res_prev   = '0;
      idle();
      for (int c = 0; c < 4000 && (issued < 300 || exp_q.size() > 0); c++) begin
         if (!in_valid && issued < 300 && $urandom_range(0, 4) != 0)
            drive(ops[$urandom_range(0, 10)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
         out_ready = ($urandom_range(0, 9) < 7);
         step();
         if (stall_prev) begin
            total++;
            if (o_vld !== 1'b1 || o_res !== res_prev) begin
               bad++;
               $display("FAIL rnd_hold: vld=%b res=%h want 1 %h", o_vld, o_res, res_prev);
            end
         end
         stall_prev = o_vld & ~com;
         res_prev   = o_res;
         if (acc) begin
            issued++;
            idle();
         end
         if (com) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rnd_spurious: got %h with nothing pending", o_res);
            end else begin
               e = exp_q.pop_front();
               if (o_res !== e.res || o_z !== e.z || o_ov !== e.ov) begin
                  bad++;
                  $display("FAIL rnd_result: got %h z=%b ov=%b want %h z=%b ov=%b",
                           o_res, o_z, o_ov, e.res, e.z, e.ov);
               end
            end
         end
      end
      total++;
      if (issued != 300 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL rnd_timeout: issued=%0d pending=%0d want 300 0",
                  issued, exp_q.size());
      end
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_imm();
      test_forward();
      test_back_pressure();
      test_ovfl_zero();
      test_reg0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle register-read / sign-extend / mux / ALU datapath.
- Owns its register file, including the write-back path.
- Accepts one instruction per cycle through a valid/ready handshake.
- Forwards results between back-to-back dependent instructions and stalls cleanly on output back-pressure.
- Sits between the future decode/control unit (upstream) and the memory/write-back consumer (downstream).

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, register count; register 0 reads as zero and ignores writes.
- IMM_W, 16, immediate width; sign-extended to XLEN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept this cycle.
- rs_number  in  $clog2(NREGS)  source A register.
- rt_number  in  $clog2(NREGS)  source B register.
- rd_number  in  $clog2(NREGS)  destination register.
- imm  in  IMM_W  immediate.
- alu_src  in  1  0 selects the rt value, 1 selects sign-extended imm.
- alu_control  in  4  operation code.
- reg_write  in  1  write the result to rd on commit.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- alu_result  out  XLEN  result.
- zero  out  1  alu_result equals 0.
- ovfl  out  1  signed overflow; ADD/SUB only, else 0.

Behaviour:
- Reset (async, active-high):
  - All registers in the register file clear to 0.
  - X-stage and O-stage valid bits clear to 0.
  - alu_result, zero and ovfl clear to 0.
  - in_ready reads 1 once reset deasserts.
  - Reset mid-operation discards every in-flight instruction; no write-back occurs.
- Stages:
  - X (execute input): holds rs/rt/rd numbers, raw operand values, sign-extended imm, alu_src, alu_control and reg_write.
  - O (output): holds result, zero, ovfl, rd and reg_write.
- Handshakes:
  - accept = in_valid & in_ready.
  - commit = out_valid & out_ready.
  - out_valid = O.valid.
  - advance = X.valid & (!O.valid | commit); on advance, X moves into O.
  - in_ready = !X.valid | advance.
- Latency: instruction accepted in cycle t is presented with out_valid=1 in cycle t+2 at the earliest. Throughput is 1 per cycle while out_ready=1.
- Operand read at accept:
  - The register file is read combinationally.
  - If a commit writes the same nonzero register in the same cycle, the new value is captured (write-through bypass).
- Operand forward at execute:
  - Applies when O.valid & O.reg_write & O.rd != 0 & O.rd == X.rs (or X.rt).
  - In that case the operand is O.result instead of the captured raw value.
  - Forwarding applies to rt only when alu_src=0.
- Write-back: on commit with reg_write=1 and rd != 0, regfile[rd] <= alu_result at the clock edge.
- Stall: when out_valid=1 and out_ready=0:
  - O holds all outputs stable.
  - X holds if valid.
  - in_ready equals !X.valid.
  - Held outputs must not change until commit.
- alu_control encoding (unlisted codes yield 0, ovfl=0):
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB.
  - 0111 SLT (signed compare; result 1 or 0).
  - 1100 NOR.
  - 0011 XOR.
  - 1000 SLL by srcB[$clog2(XLEN)-1:0].
  - 1001 SRL.
  - 1010 SRA.
- Arithmetic:
  - Results wrap modulo 2^XLEN.
  - ADD ovfl = operands have the same sign and the result sign differs.
  - SUB ovfl = operands have different signs and the result sign differs from A.
  - zero is computed from the final result.
- Simultaneous events:
  - Accept, advance and commit may all occur in one cycle.
  - Write-back and write-through bypass resolve in that same cycle.

Decomposition:
- Package pipelined_datapath_pkg holds:
  - The alu_op_e enum (the codes above).
  - An x_stage_t struct and an o_stage_t struct.
  - A localparam function for register-index width.
- One natural sub-module: regfile_2r1w (two asynchronous read ports, one synchronous write port, write-through bypass, register 0 hardwired to zero).
- The ALU stays a combinational always block in the top module.

Test Plan:
- Reset mid-stream: after reset, read r1 via ADD r1+r0 -> 0. in_ready=1 and out_valid=0 the cycle after reset releases.
- Immediate path: ADD r1=r0+imm 0x0005, then ADD r2=r0+imm 0xFFFF -> results 5 and 0xFFFFFFFF, out_valid at t+2 and t+3.
- Back-to-back forwarding (out_ready=1):
  - r1=7.
  - Next instruction r2 = r1 + r1 -> 14.
  - Next instruction r3 = r2 SUB r1 -> 7.
  - No bubbles between results.
- Back-pressure: hold out_ready=0 for 4 cycles with two instructions in flight -> outputs stable, in_ready=0, no regfile write. On release, results commit in order on consecutive cycles.
- Overflow/zero:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, ovfl=1.
  - SUB 5-5 -> 0, zero=1, ovfl=0.
  - SLT -1<1 -> 1.
- Register 0: write rd=0 with 0x1234, then ADD r0+r0 -> 0. No forwarding from rd=0.
